// File: rtl/rose_impl_monitor_pkg.sv
// Shared types and the saturating-increment helper for the a |-> $rose(b) monitor.
package rose_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL, V_VAC} verdict_e;

  // Width-generic: callers widen to 32 bits and truncate the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rose_edge_det.sv
// Rising-edge detector: registers b every cycle, regardless of monitor state.
module rose_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic b,
  output logic rose
);

  logic b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_q <= 1'b0;
    else        b_q <= b;
  end

  assign rose = b & ~b_q;

endmodule

// File: rtl/rose_impl_monitor.sv
// Monitor for a |-> $rose(b): verdict pulses, saturating counters, sticky error and stamp.
module rose_impl_monitor
  import rose_chk_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned TS_W         = 16,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt,
  output logic             err_sticky,
  output logic [TS_W-1:0]  first_fail_cycle,
  output logic             halted
);

  logic            rose;
  logic [TS_W-1:0] cycle_cnt;
  state_e          state_q;
  verdict_e        verdict;

  rose_edge_det u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .b    (b),
    .rose (rose)
  );

  // clr discards the sample in its own cycle.
  always_comb begin
    verdict = V_NONE;
    if (en && (state_q != HALT) && !clr) begin
      if (!a)        verdict = V_VAC;
      else if (rose) verdict = V_PASS;
      else           verdict = V_FAIL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt        <= '0;
      state_q          <= IDLE;
      pass_pulse       <= 1'b0;
      fail_pulse       <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      vac_cnt          <= '0;
      err_sticky       <= 1'b0;
      first_fail_cycle <= '0;
      halted           <= 1'b0;
    end else begin
      cycle_cnt  <= cycle_cnt + 1'b1;
      pass_pulse <= (verdict == V_PASS);
      fail_pulse <= (verdict == V_FAIL);
      if (clr) begin
        state_q          <= IDLE;
        pass_cnt         <= '0;
        fail_cnt         <= '0;
        vac_cnt          <= '0;
        err_sticky       <= 1'b0;
        first_fail_cycle <= '0;
        halted           <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE:    if (en)  state_q <= RUN;
          RUN:     if (!en) state_q <= IDLE;
          HALT:    state_q <= HALT;
          default: state_q <= IDLE;
        endcase
        unique case (verdict)
          V_PASS: pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), CNT_W));
          V_VAC:  vac_cnt  <= CNT_W'(sat_inc(32'(vac_cnt), CNT_W));
          V_FAIL: begin
            fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), CNT_W));
            if (!err_sticky) begin
              err_sticky       <= 1'b1;
              first_fail_cycle <= cycle_cnt;
            end
            // A fail seen on the first enabled cycle (still IDLE) halts as well.
            if (STOP_ON_FAIL) begin
              state_q <= HALT;
              halted  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
